gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
- Controller that sequences a WIDTH-bit Gray-code counter through a programmed number of steps, up or down, under a start/busy/done handshake.
- Supports pause and abort.
- Sits between a control master (testbench or host FSM) and the Gray counter datapath, which it instantiates internally.
- Used wherever a bounded, glitch-free Gray-coded step sequence is needed, for example pointer stepping or encoder emulation.

Parameters:
- WIDTH, 4: Gray counter width in bits (minimum 2).
- CNT_W, 8: width of the step-count request.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset asserted).
- start  input  1  request to begin a sequence; sampled only in IDLE.
- dir  input  1  direction, 0 = up (forward Gray order), 1 = down; latched on an accepted start.
- steps  input  CNT_W  number of advances to perform; latched on an accepted start.
- pause  input  1  level; hold the counter while high.
- abort  input  1  level; terminate the sequence immediately.
- gray_out  output  WIDTH  current Gray code (registered).
- busy  output  1  high in RUN or HOLD.
- done  output  1  high for exactly one cycle, in DONE.

Behaviour:
- Reset (rst=0, no clock required):
  - cs=IDLE; gray_out=0; busy=0; done=0; internal remaining count=0; latched dir=0.
  - Reset asserted mid-sequence aborts it with the same values; no done pulse.
- State register cs, 2-bit encoding: IDLE=2'b00, RUN=2'b01, HOLD=2'b10, DONE=2'b11. Moore outputs busy and done are decoded from cs.
- IDLE:
  - start=1 and steps!=0: latch dir and steps into remaining; next cs=RUN. The counter does not advance on this edge.
  - start=1 and steps==0: next cs=DONE; counter unchanged.
  - start=0: stay in IDLE.
- RUN, per edge, priority abort > pause > advance:
  - abort=1: next cs=IDLE; counter frozen; no done.
  - pause=1: next cs=HOLD; no advance on this edge.
  - Otherwise: counter advances one Gray step in the latched direction and remaining decrements. If remaining==1 before the edge, next cs=DONE; else stay in RUN.
- HOLD:
  - abort=1: next cs=IDLE.
  - pause=0: next cs=RUN, with no advance on this edge.
  - Otherwise stay in HOLD; the counter holds.
- DONE: done=1 for that cycle; next cs=IDLE unconditionally. start is ignored in DONE.
- start is ignored in RUN, HOLD and DONE. dir and steps changes after acceptance have no effect.
- Latency: start accepted at edge k; first gray_out change at edge k+1; for N steps with no pause, done is high during the cycle after edge k+N.
- Gray arithmetic:
  - The internal binary counter b is WIDTH bits, modulo 2^WIDTH, and wraps in both directions.
  - gray_out = b ^ (b >> 1), registered alongside b. Successive gray_out values differ in exactly 1 bit.
  - Up from all-max binary wraps to 0; down from 0 wraps to 2^WIDTH−1.
- The counter value persists across sequences: a new sequence continues from the current gray_out.

Optional Feature:
- Macro: GRAY_SEQ_CLR_ON_START_EN.
- Defined: an accepted start (including steps==0) also clears b and gray_out to 0 on the accepting edge, so every sequence begins at code 0.
- Undefined: start never modifies the counter; sequences resume from the current value.

Decomposition:
- Shared package gray_seq_pkg holds:
  - State encodings IDLE/RUN/HOLD/DONE.
  - Direction constants DIR_UP=0 and DIR_DOWN=1.
  - A bin2gray function.
- One sub-module, gray_step_counter:
  - Parameter WIDTH.
  - Ports clk, rst, en, dir, clr, gray_out.
  - Contains the binary register and Gray encode.
- The FSM, remaining counter and handshake stay in gray_seq_ctrl.
- The bench keeps a behavioural golden Gray counter and compares gray_out every negedge. It checks DUT.cs against the package state constants.

Test Plan (WIDTH=2, CNT_W=8, feature undefined unless stated):
- Reset: rst=0 at t=0, check at #2 with no edge -> cs=IDLE, gray_out=00, busy=0, done=0. Reassert rst mid-RUN -> same values immediately and no done pulse.
- Up wrap: start, dir=0, steps=5 from 00 -> gray_out at successive negedges after acceptance = 01, 11, 10, 00, 01. The next cycle has cs=DONE, done=1, busy=0; the cycle after has cs=IDLE and done=0.
- Down: dir=1, steps=3 from 00 -> 10, 11, 01; then done for one cycle; gray_out stays 01.
- Pause/abort: dir=0, steps=4, pause=1 after 2 advances (gray_out=11) for 3 cycles -> cs=HOLD and gray_out=11 held. On pause=0, one no-advance edge to RUN, then 10, 00, then done. A separate run with abort=1 in RUN -> cs=IDLE next edge, gray_out frozen, done never asserted.
- Corner: steps=0 -> cs=DONE next edge and gray_out unchanged. start pulsed during RUN with different dir/steps -> ignored, and the original sequence completes unchanged.
- With GRAY_SEQ_CLR_ON_START_EN defined, from gray_out=10, start with steps=2 -> gray_out=00 on the accepting edge, then 01, 11, then done.

Source files
------------

// File: rtl/gray_seq_pkg.sv
// Shared definitions for the Gray-code step sequencer: state encodings,
// direction constants and the binary-to-Gray helper.
package gray_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Sized for the widest counter we expect; callers truncate to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step_counter.sv
// Binary up/down counter with registered Gray encode; clr has priority over en.
// Wraps modulo 2^WIDTH in both directions.
module gray_step_counter
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] gray_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] gray_nxt;

  always_comb begin
    b_nxt    = (dir == DIR_DOWN) ? (b - ONE) : (b + ONE);
    gray_nxt = WIDTH'(bin2gray(32'(b_nxt)));
  end

  // gray_out is registered alongside b so it never glitches between codes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b        <= '0;
      gray_out <= '0;
    end else if (clr) begin
      b        <= '0;
      gray_out <= '0;
    end else if (en) begin
      b        <= b_nxt;
      gray_out <= gray_nxt;
    end
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Sequences a Gray counter through a programmed step count under start/busy/done.
// Build option GRAY_SEQ_CLR_ON_START_EN: an accepted start also zeroes the counter.
//
//   state | meaning
//   IDLE  | waiting for start; counter holds its last value
//   RUN   | one Gray step per cycle until remaining reaches zero
//   HOLD  | paused; counter and remaining frozen
//   DONE  | one-cycle completion pulse, then back to IDLE
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             done
);

`ifdef GRAY_SEQ_CLR_ON_START_EN
  localparam logic CLR_ON_START = 1'b1;
`else
  localparam logic CLR_ON_START = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           cs;
  state_t           ns;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] rem_nxt;
  logic             dir_q;
  logic             dir_nxt;
  logic             cnt_en;
  logic             cnt_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs        <= IDLE;
      remaining <= '0;
      dir_q     <= DIR_UP;
    end else begin
      cs        <= ns;
      remaining <= rem_nxt;
      dir_q     <= dir_nxt;
    end
  end

  always_comb begin
    ns      = cs;
    rem_nxt = remaining;
    dir_nxt = dir_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    case (cs)
      IDLE: begin
        if (start) begin
          cnt_clr = CLR_ON_START;
          if (steps != '0) begin
            ns      = RUN;
            rem_nxt = steps;
            dir_nxt = dir;
          end else begin
            ns = DONE;
          end
        end
      end
      RUN: begin
        // abort beats pause beats advance
        if (abort) begin
          ns = IDLE;
        end else if (pause) begin
          ns = HOLD;
        end else begin
          cnt_en  = 1'b1;
          rem_nxt = remaining - CNT_ONE;
          if (remaining == CNT_ONE) ns = DONE;
        end
      end
      HOLD: begin
        if (abort)       ns = IDLE;
        else if (!pause) ns = RUN;
      end
      DONE:    ns = IDLE;
      default: ns = IDLE;
    endcase
  end

  assign busy = (cs == RUN) || (cs == HOLD);
  assign done = (cs == DONE);

  gray_step_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .dir      (dir_q),
    .clr      (cnt_clr),
    .gray_out (gray_out)
  );

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl (WIDTH=2) with a golden binary counter
// feeding a queue of expected Gray codes, compared at negedges.
module tb_gray_seq_ctrl;
  import gray_seq_pkg::*;

  localparam int WIDTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] steps;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] gray_out;
  logic             busy;
  logic             done;

  int               n_checks;
  int               n_pass;
  logic [WIDTH-1:0] gb;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] e;

  gray_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .steps(steps),
    .pause(pause), .abort(abort), .gray_out(gray_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] g(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    gb  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; dir = 1'b0; steps = '0; pause = 1'b0; abort = 1'b0;
    gb = '0;
    #2;
    n_checks++; if (dut.cs !== IDLE) $display("FAIL reset_cs: got %0d exp %0d", dut.cs, IDLE); else n_pass++;
    n_checks++; if (gray_out !== 2'b00) $display("FAIL reset_gray: got %b exp 00", gray_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else n_pass++;
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_up_wrap();
    start = 1'b1; dir = DIR_UP; steps = 8'd5;
    tick();
    start = 1'b0;
    n_checks++; if (dut.cs !== RUN) $display("FAIL up_accept_cs: got %0d exp %0d", dut.cs, RUN); else n_pass++;
    n_checks++; if (gray_out !== g(gb)) $display("FAIL up_accept_gray: got %b exp %b", gray_out, g(gb)); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL up_accept_busy: got %b exp 1", busy); else n_pass++;
    for (int i = 0; i < 5; i++) begin gb = gb + 2'd1; exp_q.push_back(g(gb)); end
    for (int i = 0; i < 5; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if (gray_out !== e) $display("FAIL up_gray%0d: got %b exp %b", i, gray_out, e); else n_pass++;
      n_checks++; if (dut.cs !== ((i == 4) ? DONE : RUN)) $display("FAIL up_cs%0d: got %0d", i, dut.cs); else n_pass++;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL up_done: got %b exp 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL up_done_busy: got %b exp 0", busy); else n_pass++;
    tick();
    n_checks++; if (dut.cs !== IDLE) $display("FAIL up_idle_cs: got %0d exp %0d", dut.cs, IDLE); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL up_idle_done: got %b exp 0", done); else n_pass++;
  endtask

  task automatic test_down();
    rst_pulse();
    start = 1'b1; dir = DIR_DOWN; steps = 8'd3;
    tick();
    start = 1'b0; dir = DIR_UP; steps = 8'd9;
    for (int i = 0; i < 3; i++) begin gb = gb - 2'd1; exp_q.push_back(g(gb)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if (gray_out !== e) $display("FAIL down_gray%0d: got %b exp %b", i, gray_out, e); else n_pass++;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL down_done: got %b exp 1", done); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL down_done_once: got %b exp 0", done); else n_pass++;
    n_checks++; if (gray_out !== 2'b01) $display("FAIL down_final: got %b exp 01", gray_out); else n_pass++;
  endtask

  task automatic test_pause();
    rst_pulse();
    start = 1'b1; dir = DIR_UP; steps = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin gb = gb + 2'd1; exp_q.push_back(g(gb)); end
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if (gray_out !== e) $display("FAIL pause_pre%0d: got %b exp %b", i, gray_out, e); else n_pass++;
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (dut.cs !== HOLD) $display("FAIL pause_cs%0d: got %0d exp %0d", i, dut.cs, HOLD); else n_pass++;
      n_checks++; if (gray_out !== 2'b11) $display("FAIL pause_hold%0d: got %b exp 11", i, gray_out); else n_pass++;
    end
    pause = 1'b0;
    tick();
    n_checks++; if (dut.cs !== RUN) $display("FAIL pause_resume_cs: got %0d exp %0d", dut.cs, RUN); else n_pass++;
    n_checks++; if (gray_out !== 2'b11) $display("FAIL pause_resume_gray: got %b exp 11", gray_out); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if (gray_out !== e) $display("FAIL pause_post%0d: got %b exp %b", i, gray_out, e); else n_pass++;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL pause_done: got %b exp 1", done); else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    start = 1'b1; dir = DIR_UP; steps = 8'd6;
    tick();
    start = 1'b0;
    gb = gb + 2'd1; exp_q.push_back(g(gb));
    tick();
    e = exp_q.pop_front();
    n_checks++; if (gray_out !== e) $display("FAIL abort_pre: got %b exp %b", gray_out, e); else n_pass++;
    abort = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (dut.cs !== IDLE) $display("FAIL abort_cs%0d: got %0d exp %0d", i, dut.cs, IDLE); else n_pass++;
      n_checks++; if (gray_out !== g(gb)) $display("FAIL abort_frozen%0d: got %b exp %b", i, gray_out, g(gb)); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL abort_nodone%0d: got %b exp 0", i, done); else n_pass++;
    end
    abort = 1'b0;
    start = 1'b1; steps = 8'd6;
    tick();
    start = 1'b0; pause = 1'b1;
    tick();
    n_checks++; if (dut.cs !== HOLD) $display("FAIL abort_hold_cs: got %0d exp %0d", dut.cs, HOLD); else n_pass++;
    abort = 1'b1;
    tick();
    n_checks++; if (dut.cs !== IDLE) $display("FAIL abort_from_hold: got %0d exp %0d", dut.cs, IDLE); else n_pass++;
    n_checks++; if (gray_out !== g(gb)) $display("FAIL abort_hold_gray: got %b exp %b", gray_out, g(gb)); else n_pass++;
    abort = 1'b0; pause = 1'b0;
  endtask

  task automatic test_zero_steps();
    start = 1'b1; steps = 8'd0;
    tick();
    n_checks++; if (dut.cs !== DONE) $display("FAIL zero_cs: got %0d exp %0d", dut.cs, DONE); else n_pass++;
    n_checks++; if (gray_out !== g(gb)) $display("FAIL zero_gray: got %b exp %b", gray_out, g(gb)); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done: got %b exp 1", done); else n_pass++;
    steps = 8'd3;
    tick();
    start = 1'b0;
    n_checks++; if (dut.cs !== IDLE) $display("FAIL zero_ignore_start: got %0d exp %0d", dut.cs, IDLE); else n_pass++;
  endtask

  task automatic test_start_in_run();
    start = 1'b1; dir = DIR_UP; steps = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin gb = gb + 2'd1; exp_q.push_back(g(gb)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin start = 1'b1; dir = DIR_DOWN; steps = 8'd7; end
      e = exp_q.pop_front();
      n_checks++; if (gray_out !== e) $display("FAIL b2b_gray%0d: got %b exp %b", i, gray_out, e); else n_pass++;
      n_checks++; if (dut.cs !== ((i == 2) ? DONE : RUN)) $display("FAIL b2b_cs%0d: got %0d", i, dut.cs); else n_pass++;
    end
    start = 1'b0; dir = DIR_UP;
    tick();
    n_checks++; if (dut.cs !== IDLE) $display("FAIL b2b_idle: got %0d exp %0d", dut.cs, IDLE); else n_pass++;
  endtask

  task automatic test_mid_reset();
    start = 1'b1; dir = DIR_UP; steps = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin gb = gb + 2'd1; exp_q.push_back(g(gb)); end
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if (gray_out !== e) $display("FAIL mrst_pre%0d: got %b exp %b", i, gray_out, e); else n_pass++;
    end
    #2 rst = 1'b0;
    #1;
    gb = '0;
    n_checks++; if (dut.cs !== IDLE) $display("FAIL mrst_cs: got %0d exp %0d", dut.cs, IDLE); else n_pass++;
    n_checks++; if (gray_out !== 2'b00) $display("FAIL mrst_gray: got %b exp 00", gray_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mrst_busy: got %b exp 0", busy); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (done !== 1'b0) $display("FAIL mrst_nodone%0d: got %b exp 0", i, done); else n_pass++;
    end
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_origin();
    rst_pulse();
    start = 1'b1; dir = DIR_UP; steps = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin gb = gb + 2'd1; tick(); end
    n_checks++; if (gray_out !== 2'b10) $display("FAIL origin_setup: got %b exp 10", gray_out); else n_pass++;
    tick();
    start = 1'b1; steps = 8'd2;
    tick();
    start = 1'b0;
`ifdef GRAY_SEQ_CLR_ON_START_EN
    gb = '0;
`endif
    n_checks++; if (gray_out !== g(gb)) $display("FAIL origin_accept: got %b exp %b", gray_out, g(gb)); else n_pass++;
    for (int i = 0; i < 2; i++) begin gb = gb + 2'd1; exp_q.push_back(g(gb)); end
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if (gray_out !== e) $display("FAIL origin_gray%0d: got %b exp %b", i, gray_out, e); else n_pass++;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL origin_done: got %b exp 1", done); else n_pass++;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_up_wrap();
    test_down();
    test_pause();
    test_abort();
    test_zero_steps();
    test_start_in_run();
    test_mid_reset();
    test_start_origin();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
